// File: rtl/diff_acc_pkg.sv
// rtl/diff_acc_pkg.sv - shared types and helpers for the difference accumulator
package diff_acc_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Largest total representable in an acc_width-bit signed accumulator.
    function automatic int acc_max(input int acc_width);
        return (1 << (acc_width - 1)) - 1;
    endfunction

    // Smallest total representable in an acc_width-bit signed accumulator.
    function automatic int acc_min(input int acc_width);
        return -(1 << (acc_width - 1));
    endfunction

    // Replicates bit w-1 of v into every bit above it.
    function automatic logic [63:0] sign_extend(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = v;
        for (int b = 0; b < 64; b++) begin
            if (b >= w) begin
                r[b] = v[w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/diff_accumulator_if.sv
// rtl/diff_accumulator_if.sv - sample input, total output and status signals
interface diff_accumulator_if #(
    parameter int WIDTH       = 2,
    parameter int ACC_WIDTH   = 8,
    parameter int COUNT_WIDTH = 4
);
    logic [WIDTH-1:0]       i;
    logic                   i_valid;
    logic                   i_ready;
    logic                   clr;
    logic [ACC_WIDTH-1:0]   o;
    logic                   o_valid;
    logic                   o_ready;
    logic                   ovf;
    logic [COUNT_WIDTH-1:0] count;

    // Environment side: produces samples and consumes totals.
    modport master (
        output i, i_valid, clr, o_ready,
        input  i_ready, o, o_valid, ovf, count
    );

    // Accumulator side.
    modport slave (
        input  i, i_valid, clr, o_ready,
        output i_ready, o, o_valid, ovf, count
    );
endinterface

// File: rtl/diff_accumulator_sat_add.sv
// rtl/diff_accumulator_sat_add.sv - signed add of a difference to the total, clamped to accumulator range
module sat_add
    import diff_acc_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int ACC_WIDTH = 8
) (
    input  logic [WIDTH-1:0]     i,
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);
    // One guard bit is enough: |i| is always smaller than the accumulator range.
    localparam int SW = ACC_WIDTH + 1;
    localparam logic signed [SW-1:0] MAX_V = SW'(acc_max(ACC_WIDTH));
    localparam logic signed [SW-1:0] MIN_V = SW'(acc_min(ACC_WIDTH));

    logic signed [SW-1:0] raw;

    assign raw = SW'(sign_extend(64'(i), WIDTH)) + SW'(sign_extend(64'(acc), ACC_WIDTH));

    // Clamp the widened sum back into range and flag when clamping happened.
    always_comb begin
        ovf = 1'b0;
        sum = raw[ACC_WIDTH-1:0];
        if (raw > MAX_V) begin
            sum = MAX_V[ACC_WIDTH-1:0];
            ovf = 1'b1;
        end else if (raw < MIN_V) begin
            sum = MIN_V[ACC_WIDTH-1:0];
            ovf = 1'b1;
        end
    end
endmodule

// File: rtl/diff_accumulator.sv
// rtl/diff_accumulator.sv - saturating running total of subtractor differences with a one-entry output stage
module diff_accumulator
    import diff_acc_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int ACC_WIDTH   = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    diff_accumulator_if.slave bus
);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   ovf_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic [ACC_WIDTH-1:0]   next_acc;
    logic                   add_ovf;
    logic                   i_ready;
    logic                   in_fire;
    logic                   out_fire;

    sat_add #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .i   (bus.i),
        .acc (acc),
        .sum (next_acc),
        .ovf (add_ovf)
    );

    // Accept when the output slot is free or is being drained this cycle; never during clear or reset.
    assign i_ready  = !rst && !bus.clr && ((state == EMPTY) || bus.o_ready);
    assign in_fire  = bus.i_valid && i_ready;
    assign out_fire = (state == FULL) && bus.o_ready;

    assign bus.i_ready = i_ready;
    assign bus.o       = acc;
    assign bus.o_valid = (state == FULL);
    assign bus.ovf     = ovf_q;
    assign bus.count   = count_q;

    // Output-stage FSM with the total, sticky overflow flag and saturating sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            acc     <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else if (bus.clr) begin
            state   <= EMPTY;
            acc     <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else if (in_fire) begin
            state <= FULL;
            acc   <= next_acc;
            if (add_ovf) begin
                ovf_q <= 1'b1;
            end
            if (count_q != COUNT_MAX) begin
                count_q <= count_q + 1'b1;
            end
        end else if (out_fire) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_diff_accumulator.sv
// tb/tb_diff_accumulator.sv - self-checking bench for diff_accumulator
module tb_diff_accumulator;
    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    int m_total;
    bit m_ovf;
    int m_count;
    bit m_valid;

    diff_accumulator_if #(.WIDTH(2), .ACC_WIDTH(8), .COUNT_WIDTH(4)) bus ();

    diff_accumulator #(
        .WIDTH       (2),
        .ACC_WIDTH   (8),
        .COUNT_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_total = 0;
        m_ovf   = 1'b0;
        m_count = 0;
        m_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".o"}, 32'(bus.o), 32'(m_total & 8'hFF));
        chk({tag, ".o_valid"}, 32'(bus.o_valid), 32'(m_valid));
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
        chk({tag, ".count"}, 32'(bus.count), 32'(m_count));
    endtask

    // One clock of stimulus: drive at the falling edge, check ready, advance the model, check outputs.
    task automatic step(input string tag, input logic v, input logic [1:0] d,
                        input logic ordy, input logic c);
        bit exp_ready;
        bit fi;
        bit fo;
        int t;
        bus.i_valid = v;
        bus.i       = d;
        bus.o_ready = ordy;
        bus.clr     = c;
        #1;
        exp_ready = !c && (!m_valid || ordy);
        chk({tag, ".i_ready"}, 32'(bus.i_ready), 32'(exp_ready));
        fi = v && exp_ready;
        fo = m_valid && ordy;
        @(posedge clk);
        if (c) begin
            model_clear();
        end else if (fi) begin
            t = m_total + int'($signed(d));
            if (t > 127) begin
                t = 127;
                m_ovf = 1'b1;
            end else if (t < -128) begin
                t = -128;
                m_ovf = 1'b1;
            end
            m_total = t;
            m_count = (m_count < 15) ? m_count + 1 : 15;
            m_valid = 1'b1;
        end else if (fo) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_clear();
        rst         = 1'b1;
        bus.i       = 2'b00;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        bus.clr     = 1'b0;
        #1;
        check_outputs("reset");
        chk("reset.i_ready", 32'(bus.i_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic accumulation: +1 three times, then -1.
        for (int k = 0; k < 3; k++) step("basic_inc", 1'b1, 2'b01, 1'b1, 1'b0);
        chk("basic.o_is_3", 32'(bus.o), 32'd3);
        step("basic_dec", 1'b1, 2'b11, 1'b1, 1'b0);
        chk("basic.o_is_2", 32'(bus.o), 32'd2);
        chk("basic.count_is_4", 32'(bus.count), 32'd4);

        // Positive saturation.
        step("pos_clr", 1'b0, 2'b00, 1'b1, 1'b1);
        for (int k = 0; k < 130; k++) step("pos_sat", 1'b1, 2'b01, 1'b1, 1'b0);
        chk("pos.o_is_127", 32'(bus.o), 32'd127);
        chk("pos.ovf_set", 32'(bus.ovf), 32'd1);
        chk("pos.count_held", 32'(bus.count), 32'd15);

        // Negative saturation.
        step("neg_clr", 1'b0, 2'b00, 1'b1, 1'b1);
        for (int k = 0; k < 70; k++) step("neg_sat", 1'b1, 2'b10, 1'b1, 1'b0);
        chk("neg.o_is_80", 32'(bus.o), 32'h80);
        chk("neg.ovf_set", 32'(bus.ovf), 32'd1);

        // Backpressure, then simultaneous pop/push.
        step("bp_clr", 1'b0, 2'b00, 1'b1, 1'b1);
        for (int k = 0; k < 11; k++) step("bp_hold", 1'b1, 2'b01, 1'b0, 1'b0);
        chk("bp.o_held", 32'(bus.o), 32'd1);
        step("bp_poppush", 1'b1, 2'b01, 1'b1, 1'b0);
        chk("bp.o_is_2", 32'(bus.o), 32'd2);
        chk("bp.still_valid", 32'(bus.o_valid), 32'd1);

        // Clear while full with overflow set and a sample offered.
        for (int k = 0; k < 130; k++) step("clr_fill", 1'b1, 2'b01, 1'b1, 1'b0);
        step("clr_full", 1'b0, 2'b00, 1'b0, 1'b0);
        step("clr_vs_in", 1'b1, 2'b01, 1'b0, 1'b1);
        chk("clr.o_zero", 32'(bus.o), 32'd0);
        chk("clr.ovf_zero", 32'(bus.ovf), 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset between edges while full with O=5.
        step("ar_clr", 1'b0, 2'b00, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) step("ar_fill", 1'b1, 2'b01, 1'b1, 1'b0);
        step("ar_hold", 1'b0, 2'b00, 1'b0, 1'b0);
        chk("ar.o_is_5", 32'(bus.o), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs("async_rst");
        chk("async_rst.i_ready", 32'(bus.i_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b1, 2'b11, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/diff_accumulator.md
Name: diff_accumulator

Overview:
- Downstream consumer of the N-bit two's-complement subtractor stage (A + ~B datapath): takes each difference word and keeps a signed, saturating running total.
- Each accepted difference produces one updated total on the output.
- A one-entry registered output stage with valid/ready on both sides, so the block sits between the subtractor and LED/UART reporting logic.

Parameters:
- WIDTH, 2, width of the incoming difference word (matches the subtractor width).
- ACC_WIDTH, 8, width of the signed accumulator and O; must be greater than WIDTH.
- COUNT_WIDTH, 4, width of the saturating accepted-sample counter.

Ports:
- CLK  input  1  single clock; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- I  input  WIDTH  difference from subtractor, two's complement.
- I_VALID  input  1  I holds a sample.
- I_READY  output  1  block accepts I this cycle.
- CLR  input  1  synchronous clear of total, count and flags.
- O  output  ACC_WIDTH  signed running total.
- O_VALID  output  1  O holds an unconsumed total.
- O_READY  input  1  downstream consumes O this cycle.
- OVF  output  1  sticky saturation flag.
- COUNT  output  COUNT_WIDTH  samples accepted since reset/CLR, saturating.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - acc=0, O=0, O_VALID=0, OVF=0, COUNT=0, state=EMPTY.
  - I_READY is 0 while RESET is high and follows the rules below from the first edge after deassertion.
- States:
  - EMPTY: O_VALID=0.
  - FULL: O_VALID=1.
- Handshakes:
  - in_fire = I_VALID & I_READY.
  - out_fire = O_VALID & O_READY.
  - I_READY = !CLR & (!O_VALID | O_READY). This is combinational, so there is no bubble under continuous flow.
- Accumulation:
  - On in_fire, I is sign-extended to ACC_WIDTH+1 and added to acc.
  - The result is saturated to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - acc, O and COUNT update at that edge.
- Latency: O reflects a sample 1 cycle after its in_fire edge.
- Saturation:
  - If the unsaturated sum is out of range, acc clamps and OVF sets.
  - OVF stays set until RESET or CLR.
  - A later in-range sample leaves OVF at 1.
- COUNT:
  - Increments on in_fire.
  - Holds at 2^COUNT_WIDTH-1; no wrap.
- Transitions:
  - EMPTY + in_fire -> FULL.
  - FULL + out_fire + !in_fire -> EMPTY.
  - FULL + out_fire + in_fire -> FULL, with the new total (simultaneous pop/push).
  - FULL + !O_READY -> FULL, with O held stable and I_READY=0.
- CLR (synchronous, highest priority after RESET):
  - Next edge sets acc=0, O=0, OVF=0, COUNT=0, state=EMPTY.
  - A pending unconsumed O is discarded.
  - I_READY=0 during CLR, so no sample is lost silently.
- O is always the registered acc; it never changes while O_VALID=1 and O_READY=0.

Decomposition:
- Package diff_acc_pkg:
  - state enum {EMPTY, FULL}.
  - Functions acc_max(ACC_WIDTH) and acc_min(ACC_WIDTH).
  - sign_extend helper.
- One sub-module, sat_add: combinational signed adder with clamp and overflow output, parameterised by WIDTH and ACC_WIDTH.
- The FSM, counter and flag logic stay in diff_accumulator.

Test Plan:
- Basic accumulation, defaults: reset, then O_READY=1; feed I=2'b01 three times.
  - Required: O=1,2,3 on successive cycles, COUNT=3, OVF=0.
  - Then feed I=2'b11 (-1): O=2, COUNT=4.
- Positive saturation: 130 consecutive I=2'b01.
  - Required: O reaches 127 on sample 127 and stays 127; OVF=1 from sample 128.
  - COUNT holds at 15 after sample 15.
- Negative saturation: after CLR, 70 samples of I=2'b10 (-2).
  - Required: O=-128 (8'h80) from sample 64; OVF=1 from sample 65.
- Backpressure:
  - O_READY=0 with I_VALID held and I=01: one accept, then I_READY=0, O=1 stable for 10 cycles.
  - Raise O_READY: same-cycle pop/push gives O=2 next cycle with O_VALID still 1.
- CLR vs input: CLR=1 with I_VALID=1 while FULL and OVF=1.
  - Required: I_READY=0 in that cycle.
  - Next cycle: O=0, O_VALID=0, OVF=0, COUNT=0, and the sample is not accumulated.
- Async reset mid-operation: assert RESET between clock edges while FULL with O=5.
  - Required: O=0, O_VALID=0, COUNT=0, OVF=0 immediately, without waiting for a CLK edge.
